door_controller: RTL

// Downstream of the elevator controller: turns its door command (0 idle, 1 open, 2 close)

---
 rtl/door_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/door_controller.sv
// Door controller: turns the elevator controller's door command into door-motor
// drive using the limit switches, the light curtain and the cabin buttons.
// It holds the dwell time, reopens on obstruction or nudge and latches a fault
// on a motion timeout, an inconsistent limit-switch pair or an engine interlock
// violation. door_closed_o is the safe-to-move interlock back to the controller.
module door_controller #(
   parameter int DWELL_CYCLES = 1000,  // cycles fully open before auto-close (>=2)
   parameter int MOVE_TIMEOUT = 500,   // max cycles for one stroke (>=2)
   parameter int MAX_REOPEN   = 3,     // open_btn reopens per close sequence (>=1)
   parameter int CNT_W        = 16     // must hold max(DWELL_CYCLES, MOVE_TIMEOUT)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] door_cmd_i,
   input  logic [1:0] engine_i,
   input  logic       open_btn_i,
   input  logic       close_btn_i,
   input  logic       obstruct_i,
   input  logic       lim_open_i,
   input  logic       lim_closed_i,
   output logic [1:0] door_motor_o,
   output logic       door_closed_o,
   output logic       door_busy_o,
   output logic       fault_o
);

   localparam int RW = $clog2(MAX_REOPEN + 1);

   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(MOVE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [RW-1:0]    REOPEN_MAX = RW'(MAX_REOPEN);

   typedef enum logic [2:0] {
      S_CLOSED  = 3'd0,
      S_OPENING = 3'd1,
      S_DWELL   = 3'd2,
      S_CLOSING = 3'd3,
      S_FAULT   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      MOTOR_STOP  = 2'd0,
      MOTOR_OPEN  = 2'd1,
      MOTOR_CLOSE = 2'd2
   } motor_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [RW-1:0]    reopen_q, reopen_d;

   motor_e motor_q, motor_d;
   logic   door_closed_q, door_closed_d;
   logic   door_busy_q, door_busy_d;
   logic   fault_q, fault_d;

   logic             open_req;
   logic             engine_moving;
   logic [CNT_W-1:0] timer_inc;

   assign open_req      = (door_cmd_i == 2'd1) || open_btn_i;
   assign engine_moving = (engine_i != 2'd0);
   // The stroke timer saturates instead of wrapping back to zero.
   assign timer_inc     = (timer_q == CNT_MAX) ? timer_q : timer_q + 1'b1;

   // State and output registers; the async reset also stops the motor at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_CLOSED;
         timer_q       <= '0;
         dwell_q       <= '0;
         reopen_q      <= '0;
         motor_q       <= MOTOR_STOP;
         door_closed_q <= 1'b0;
         door_busy_q   <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         timer_q       <= timer_d;
         dwell_q       <= dwell_d;
         reopen_q      <= reopen_d;
         motor_q       <= motor_d;
         door_closed_q <= door_closed_d;
         door_busy_q   <= door_busy_d;
         fault_q       <= fault_d;
      end
   end

   // Next-state and counter logic, conditions checked in priority order.
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latches).
      state_d  = state_q;
      timer_d  = timer_q;
      dwell_d  = dwell_q;
      reopen_d = reopen_q;

      if (lim_open_i && lim_closed_i) begin
         state_d = S_FAULT;
      end else if (state_q != S_CLOSED && state_q != S_FAULT && engine_moving) begin
         state_d = S_FAULT;
      end else begin
         unique case (state_q)
            S_CLOSED: begin
               if (open_req && !engine_moving) begin
                  state_d = S_OPENING;
                  timer_d = '0;
               end
            end
            S_OPENING: begin
               if (lim_open_i) begin
                  state_d = S_DWELL;
                  dwell_d = DWELL_LOAD;
               end else if (timer_q == TIMER_LAST) begin
                  state_d = S_FAULT;
               end else begin
                  timer_d = timer_inc;
               end
            end
            S_DWELL: begin
               // Obstruction or a held open button keep the door open.
               if (obstruct_i || open_btn_i) begin
                  dwell_d = DWELL_LOAD;
               end else if (close_btn_i || door_cmd_i == 2'd2 || dwell_q == '0) begin
                  state_d = S_CLOSING;
                  timer_d = '0;
               end else begin
                  dwell_d = dwell_q - 1'b1;
               end
            end
            S_CLOSING: begin
               // Obstruction reopens unconditionally; nudges are rationed.
               if (obstruct_i) begin
                  state_d = S_OPENING;
                  timer_d = '0;
               end else if (open_btn_i && reopen_q < REOPEN_MAX) begin
                  state_d  = S_OPENING;
                  timer_d  = '0;
                  reopen_d = reopen_q + 1'b1;
               end else if (lim_closed_i) begin
                  state_d  = S_CLOSED;
                  reopen_d = '0;
               end else if (timer_q == TIMER_LAST) begin
                  state_d = S_FAULT;
               end else begin
                  timer_d = timer_inc;
               end
            end
            S_FAULT: begin
               state_d = S_FAULT;
            end
            default: begin
               state_d = S_FAULT;
            end
         endcase
      end
   end

   // Output decode from the next state, so outputs register alongside the state.
   always_comb begin
      motor_d       = MOTOR_STOP;
      door_closed_d = 1'b0;
      door_busy_d   = (state_d != S_CLOSED);
      fault_d       = (state_d == S_FAULT);
      case (state_d)
         S_OPENING: motor_d       = MOTOR_OPEN;
         S_CLOSING: motor_d       = MOTOR_CLOSE;
         S_CLOSED:  door_closed_d = lim_closed_i;
         default:   motor_d       = MOTOR_STOP;
      endcase
   end

   assign door_motor_o  = motor_q;
   assign door_closed_o = door_closed_q;
   assign door_busy_o   = door_busy_q;
   assign fault_o       = fault_q;

endmodule
